serial_word_loader: RTL and testbench

Parallel-in/serial-out loader that accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on a registered serial output. It sits directly upstream of the 4-stage serial shift chain and drives that chain's serial data input. It also gives the chain's owner framing strobes (`sout_valid`, `done`). Back-to-back words stream with no idle gap.

---
 rtl/serial_word_loader.sv | 171 +++++++++++++++++
 tb/tb_serial_word_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_word_loader.sv
// serial_word_loader
// Parallel-in/serial-out loader. A WIDTH-bit word accepted over a
// valid/ready handshake is emitted one bit per clock on a registered serial
// output. This output feeds the downstream serial shift chain. Back-to-back
// words stream with no idle gap.
//
// Parameters:
//   WIDTH      data word width (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
// Macro:
//   SERIAL_WORD_LOADER_PARITY_EN  adds one even-parity bit after the data
//                                 bits. done/load_ready move to that cycle.
// Ports:
//   clk         clock, rising edge
//   clear       synchronous active-high reset, overrides a load
//   din         parallel word, sampled only on an accepted load
//   load_valid  din is valid
//   load_ready  loader can accept a word this cycle (combinational from state)
//   sout        serial data (registered, 0 whenever sout_valid is 0)
//   sout_valid  sout carries a frame bit (registered)
//   busy        frame in progress (registered)
//   done        one-cycle pulse on the last bit of a frame (registered)
module serial_word_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    ,PARITY = 2'd2
`endif
  } state_t;

  state_t          state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sout_n, sv_n, busy_n, done_n;
  logic             accept, start, last;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
  logic             par, par_n;
`endif

  // Move the next bit to the output end of the shift register.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // cnt counts remaining bits after the one currently on sout.
  assign last = (state == SHIFT) && (cnt == '0);

`ifdef SERIAL_WORD_LOADER_PARITY_EN
  assign load_ready = (state == IDLE) || (state == PARITY);
`else
  assign load_ready = (state == IDLE) || last;
`endif

  assign accept = load_valid && load_ready;

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    sout_n  = 1'b0;
    sv_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    start   = 1'b0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        start = accept;
      end
      SHIFT: begin
        if (cnt != '0) begin
          sr_n   = shift1(sr);
          cnt_n  = cnt - CW'(1);
          sout_n = head(sr_n);
          sv_n   = 1'b1;
          busy_n = 1'b1;
          // Registered done: raise it when the final data bit goes out.
`ifdef SERIAL_WORD_LOADER_PARITY_EN
          done_n = 1'b0;
`else
          done_n = (cnt == CW'(1));
`endif
        end else begin
`ifdef SERIAL_WORD_LOADER_PARITY_EN
          state_n = PARITY;
          sout_n  = par;
          sv_n    = 1'b1;
          busy_n  = 1'b1;
          done_n  = 1'b1;
`else
          start = accept;
          if (!accept) state_n = IDLE;
`endif
        end
      end
`ifdef SERIAL_WORD_LOADER_PARITY_EN
      PARITY: begin
        start = accept;
        if (!accept) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase

    // A new frame starts from IDLE or from the last cycle of a frame, with
    // its first bit driven on the very next cycle.
    if (start) begin
      state_n = SHIFT;
      sr_n    = din;
      cnt_n   = CW'(WIDTH - 1);
      sout_n  = head(din);
      sv_n    = 1'b1;
      busy_n  = 1'b1;
      done_n  = 1'b0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
      par_n   = ^din;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      cnt        <= cnt_n;
      sout       <= sout_n;
      sout_valid <= sv_n;
      busy       <= busy_n;
      done       <= done_n;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
      par        <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_serial_word_loader.sv
module tb_serial_word_loader;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = 4 + PAR;

  logic clk = 1'b0;
  logic clear;
  logic [3:0] din_a, din_b;
  logic vld_a, vld_b;
  logic rdy_a, sout_a, sv_a, busy_a, done_a;
  logic rdy_b, sout_b, sv_b, busy_b, done_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_word_loader #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .clear(clear), .din(din_a), .load_valid(vld_a),
    .load_ready(rdy_a), .sout(sout_a), .sout_valid(sv_a), .busy(busy_a), .done(done_a));

  serial_word_loader #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .clear(clear), .din(din_b), .load_valid(vld_b),
    .load_ready(rdy_b), .sout(sout_b), .sout_valid(sv_b), .busy(busy_b), .done(done_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard for dut_a: expected frame bits queued at each accept.
  typedef struct { logic b; logic d; } exp_t;
  exp_t q[$];

  always @(posedge clk) begin
    if (clear) q.delete();
    else if (vld_a && rdy_a) begin
      for (int i = 3; i >= 0; i--) q.push_back('{b: din_a[i], d: (PAR == 0 && i == 0)});
      if (PAR != 0) q.push_back('{b: ^din_a, d: 1'b1});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sv_a === 1'b1) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_extra: got unexpected bit %0b, expected none", sout_a);
      end else begin
        e = q.pop_front();
        chk("sb_sout", sout_a, e.b);
        chk("sb_done", done_a, e.d);
      end
    end else begin
      chk("idle_sout", sout_a, 1'b0);
      chk("idle_done", done_a, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  typedef struct { bit msb; logic [3:0] din; logic [3:0] seq; } vec_t;
  vec_t tv[6];

  initial begin
    logic [9:0] got, gdone, gsv, grdy, exp;
    logic r;
    // seq is the transmit order, first bit in seq[3].
    tv[0] = '{1'b1, 4'b1011, 4'b1011};
    tv[1] = '{1'b1, 4'b0001, 4'b0001};
    tv[2] = '{1'b1, 4'b1110, 4'b1110};
    tv[3] = '{1'b0, 4'b1000, 4'b0001};
    tv[4] = '{1'b0, 4'b1011, 4'b1101};
    tv[5] = '{1'b0, 4'b0110, 4'b0110};

    // Reset held with a pending load: nothing is accepted.
    clear = 1'b1; vld_a = 1'b1; din_a = 4'b1011; vld_b = 1'b0; din_b = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_sv", sv_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_sout", sout_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
    end
    clear = 1'b0;
    chk("rst_rdy", rdy_a, 1'b1);
    @(posedge clk); #1 vld_a = 1'b0;
    @(negedge clk);
    chk("rst_first", sout_a, 1'b1);
    repeat (FL + 1) @(negedge clk);

    // Table: single frames on both bit orders.
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      if (tv[t].msb) begin vld_a = 1'b1; din_a = tv[t].din; end
      else begin vld_b = 1'b1; din_b = tv[t].din; end
      @(posedge clk); #1 vld_a = 1'b0; vld_b = 1'b0;
      din_a = 4'b0101; din_b = 4'b0101;  // mid-frame changes must not matter
      got = '0; gdone = '0; gsv = '0; grdy = '0;
      for (int k = 0; k < FL; k++) begin
        @(negedge clk);
        got   = {got[8:0],   tv[t].msb ? sout_a : sout_b};
        gdone = {gdone[8:0], tv[t].msb ? done_a : done_b};
        gsv   = {gsv[8:0],   tv[t].msb ? sv_a   : sv_b};
        grdy  = {grdy[8:0],  tv[t].msb ? rdy_a  : rdy_b};
      end
      exp = 10'(tv[t].seq);
      if (PAR != 0) exp = {exp[8:0], ^tv[t].din};
      chk($sformatf("tv%0d_bits", t), got, exp);
      chk($sformatf("tv%0d_done", t), gdone, 10'd1);
      chk($sformatf("tv%0d_rdy", t), grdy, 10'd1);
      chk($sformatf("tv%0d_sv", t), gsv, (10'd1 << FL) - 10'd1);
      @(negedge clk);
      chk($sformatf("tv%0d_busy_end", t), tv[t].msb ? busy_a : busy_b, 1'b0);
      chk($sformatf("tv%0d_sout_end", t), tv[t].msb ? sout_a : sout_b, 1'b0);
    end

    // Back-to-back: 1100 then 0011 with load_valid held.
    @(posedge clk); #1;
    got = '0; gdone = '0; gsv = '0;
    fork
      begin
        vld_a = 1'b1; din_a = 4'b1100;
        @(posedge clk); #1 din_a = 4'b0011;
        r = 1'b0;
        for (int i = 0; i < 12 && !r; i++) begin
          @(negedge clk); r = rdy_a;
          @(posedge clk);
        end
        #1 vld_a = 1'b0;
        if (!r) begin
          tests++; fails++;
          $display("FAIL b2b_accept: got no second accept, expected one");
        end
      end
      begin
        @(posedge clk);
        for (int k = 0; k < 2 * FL; k++) begin
          @(negedge clk);
          got   = {got[8:0], sout_a};
          gdone = {gdone[8:0], done_a};
          gsv   = {gsv[8:0], sv_a};
        end
      end
    join
    chk("b2b_bits", got, (PAR != 0) ? 10'b1100000110 : 10'b0011000011);
    chk("b2b_done", gdone, 10'd1 | (10'd1 << FL));
    chk("b2b_sv", gsv, (10'd1 << (2 * FL)) - 10'd1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a frame.
    @(posedge clk); #1 vld_a = 1'b1; din_a = 4'b1111;
    @(posedge clk); #1 vld_a = 1'b0;
    @(negedge clk); chk("mid_sv1", sv_a, 1'b1);
    @(negedge clk); chk("mid_sv2", sv_a, 1'b1);
    clear = 1'b1;
    @(negedge clk);
    chk("mid_sv_clr", sv_a, 1'b0);
    chk("mid_busy_clr", busy_a, 1'b0);
    chk("mid_done_clr", done_a, 1'b0);
    clear = 1'b0; vld_a = 1'b1; din_a = 4'b0101;
    chk("mid_rdy", rdy_a, 1'b1);
    @(posedge clk); #1 vld_a = 1'b0;
    chk("mid_busy_new", busy_a, 1'b1);
    @(negedge clk); chk("mid_first", sout_a, 1'b0);
    repeat (FL + 1) @(negedge clk);

    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
